// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch slice.
// Holds widths, PC-select encodings and FSM state codes.
package pc_fetch_pkg;

   localparam int PC_W    = 64;
   localparam int INSTR_W = 32;

   localparam logic [1:0] PS_HOLD = 2'b00;
   localparam logic [1:0] PS_INC  = 2'b01;
   localparam logic [1:0] PS_REG  = 2'b10;
   localparam logic [1:0] PS_REL  = 2'b11;

   typedef logic [1:0] state_t;

   localparam state_t ST_FETCH = 2'b00;
   localparam state_t ST_EXEC  = 2'b01;
   localparam state_t ST_FAULT = 2'b10;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory req/ack bus between fetch unit and imem.
// The fetch unit is the master; memory is the slave.
interface pc_fetch_unit_if;
   import pc_fetch_pkg::*;

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection from the control word PS field.
// All arithmetic wraps modulo 2^64.
module pc_next_logic
   import pc_fetch_pkg::*;
(
   input  logic [PC_W-1:0] pc_i,
   input  logic [1:0]      ps_i,
   input  logic [PC_W-1:0] k_i,
   input  logic [PC_W-1:0] pc_in_i,
   output logic [PC_W-1:0] next_pc_o
);

   logic [PC_W-1:0] inc;

   assign inc = pc_i + 64'd4;

   // select next PC source
   always_comb begin
      next_pc_o = pc_i;
      unique case (ps_i)
         PS_HOLD: next_pc_o = pc_i;
         PS_INC:  next_pc_o = inc;
         PS_REG:  next_pc_o = pc_in_i;
         PS_REL:  next_pc_o = inc + {k_i[PC_W-3:0], 2'b00};
         default: next_pc_o = pc_i;
      endcase
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch FSM feeding the control unit.
// Optional misaligned-PC trap enabled by PC_MISALIGN_TRAP_EN.
module pc_fetch_unit
   import pc_fetch_pkg::*;
#(
   parameter logic [PC_W-1:0]    RESET_PC = 64'h0,
   parameter logic [INSTR_W-1:0] IR_RESET = 32'h0
)(
   input  logic               clock,
   input  logic               reset,
   input  logic [1:0]         ps,
   input  logic               ns,
   input  logic [PC_W-1:0]    k,
   input  logic [PC_W-1:0]    pc_in,
   pc_fetch_unit_if.master    imem,
   output logic [INSTR_W-1:0] instruction,
   output logic               instr_valid,
   output logic [PC_W-1:0]    pc,
   output logic [PC_W-1:0]    pc_plus4,
   output logic               fault
);

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [PC_W-1:0]    next_pc;

   pc_next_logic u_next (
      .pc_i      (pc_q),
      .ps_i      (ps),
      .k_i       (k),
      .pc_in_i   (pc_in),
      .next_pc_o (next_pc)
   );

`ifdef PC_MISALIGN_TRAP_EN
   logic fault_q, fault_d;
   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   // request is masked by reset so it drops the instant reset asserts
   assign imem.imem_req  = (state_q == ST_FETCH) && !reset;
   assign imem.imem_addr = pc_q;
   assign instr_valid    = (state_q == ST_EXEC);
   assign instruction    = ir_q;
   assign pc             = pc_q;
   assign pc_plus4       = pc_q + 64'd4;

   // fetch / execute sequencing and PC update
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
`ifdef PC_MISALIGN_TRAP_EN
      fault_d = fault_q;
`endif
      case (state_q)
         ST_FETCH: begin
            if (imem.imem_ack) begin
               ir_d    = imem.imem_rdata;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
`ifdef PC_MISALIGN_TRAP_EN
            pc_d = next_pc;
            if (next_pc[1:0] != 2'b00) begin
               fault_d = 1'b1;
               state_d = ST_FAULT;
            end else begin
               state_d = ns ? ST_EXEC : ST_FETCH;
            end
`else
            pc_d    = next_pc & ~64'h3;
            state_d = ns ? ST_EXEC : ST_FETCH;
`endif
         end
`ifdef PC_MISALIGN_TRAP_EN
         ST_FAULT: state_d = ST_FAULT;
`endif
         default: state_d = ST_FETCH;
      endcase
   end

   // state registers with asynchronous reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= IR_RESET;
`ifdef PC_MISALIGN_TRAP_EN
         fault_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
`ifdef PC_MISALIGN_TRAP_EN
         fault_q <= fault_d;
`endif
      end
   end

endmodule
